// File: rtl/mem_resp_pkg.sv
// mem_resp_pkg: shared state encoding, word geometry and latency limit for the memory responder
package mem_resp_pkg;
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        RESP = 2'd2
    } state_t;
    localparam int BYTE_OFF_W  = 2;
    localparam int WORD_W      = 32;
    localparam int MAX_LATENCY = 15;
    function automatic bit latency_ok(input int lat);
        return (lat >= 0) && (lat <= MAX_LATENCY);
    endfunction
endpackage

// File: rtl/mem_responder_if.sv
// mem_responder_if: request/response bus between the core's memory port and the responder
interface mem_responder_if import mem_resp_pkg::*; #(
    parameter int ADDR_W = 32
) ();
    logic              req_valid;
    logic              req_write;
    logic [ADDR_W-1:0] req_addr;
    logic [WORD_W-1:0] req_wdata;
    logic              req_ready;
    logic              resp_valid;
    logic [WORD_W-1:0] resp_rdata;
    logic              resp_err;
    logic              busy;
    modport master (
        output req_valid, req_write, req_addr, req_wdata,
        input  req_ready, resp_valid, resp_rdata, resp_err, busy
    );
    modport slave (
        input  req_valid, req_write, req_addr, req_wdata,
        output req_ready, resp_valid, resp_rdata, resp_err, busy
    );
endinterface

// File: rtl/resp_word_ram.sv
// resp_word_ram: single-port word RAM with registered read, contents never reset
module resp_word_ram #(
    parameter  int DEPTH  = 256,
    parameter  int WORD_W = 32,
    localparam int IW     = $clog2(DEPTH)
) (
    input  logic              cclk,
    input  logic              we,
    input  logic [IW-1:0]     index,
    input  logic [WORD_W-1:0] wdata,
    output logic [WORD_W-1:0] rdata
);
    logic [WORD_W-1:0] r_mem [DEPTH];
    // write-first is not needed: read returns the old word, write lands at the same edge
    always_ff @(posedge cclk) begin
        if (we) r_mem[index] <= wdata;
        rdata <= r_mem[index];
    end
endmodule

// File: rtl/mem_responder.sv
// mem_responder: one-at-a-time word request responder with programmable wait and error check
module mem_responder import mem_resp_pkg::*; #(
    parameter int ADDR_W  = 32,
    parameter int DEPTH   = 256,
    parameter int LATENCY = 2
) (
    input logic          cclk,
    input logic          rstb,
    mem_responder_if.slave bus
);
    localparam int                IW      = $clog2(DEPTH);
    localparam logic [ADDR_W-1:0] DEPTH_W = ADDR_W'(DEPTH);
    localparam logic [3:0]        LAT     = 4'(LATENCY);

    if (!latency_ok(LATENCY)) begin : g_bad_latency
        $error("mem_responder: LATENCY must be within 0..15");
    end

    state_t            r_state;
    logic [3:0]        r_cnt;
    logic              r_write;
    logic              r_err;
    logic [IW-1:0]     r_idx;
    logic [WORD_W-1:0] r_wdata;
    logic              r_resp_valid;
    logic [WORD_W-1:0] r_resp_rdata;
    logic              r_resp_err;
    logic              w_accept;
    logic              w_fire;
    logic              w_we;
    logic              w_addr_err;
    logic [IW-1:0]     w_idx;
    logic [WORD_W-1:0] w_ram_rdata;

    assign w_accept   = bus.req_valid && (r_state == IDLE);
    assign w_fire     = (r_state == WAIT) && (r_cnt == 4'd0);
    assign w_we       = w_fire && r_write && !r_err;
    assign w_addr_err = (bus.req_addr[BYTE_OFF_W-1:0] != '0) ||
                        ({{BYTE_OFF_W{1'b0}}, bus.req_addr[ADDR_W-1:BYTE_OFF_W]} >= DEPTH_W);
    // RAM is addressed by the incoming request at accept so that the read word is
    // already registered by the RESP-entry edge, even with zero wait cycles
    assign w_idx      = w_accept ? bus.req_addr[IW+BYTE_OFF_W-1:BYTE_OFF_W] : r_idx;

    assign bus.req_ready  = (r_state == IDLE);
    assign bus.busy       = (r_state != IDLE);
    assign bus.resp_valid = r_resp_valid;
    assign bus.resp_rdata = r_resp_rdata;
    assign bus.resp_err   = r_resp_err;

    resp_word_ram #(.DEPTH(DEPTH), .WORD_W(WORD_W)) u_ram (
        .cclk  (cclk),
        .we    (w_we),
        .index (w_idx),
        .wdata (r_wdata),
        .rdata (w_ram_rdata)
    );

    // control FSM: latch request on accept, count down the wait, emit one response pulse
    always_ff @(posedge cclk) begin
        if (!rstb) begin
            r_state      <= IDLE;
            r_cnt        <= 4'd0;
            r_resp_valid <= 1'b0;
            r_resp_rdata <= '0;
            r_resp_err   <= 1'b0;
        end else begin
            r_resp_valid <= 1'b0;
            case (r_state)
                IDLE: if (w_accept) begin
                    r_write <= bus.req_write;
                    r_err   <= w_addr_err;
                    r_idx   <= bus.req_addr[IW+BYTE_OFF_W-1:BYTE_OFF_W];
                    r_wdata <= bus.req_wdata;
                    r_cnt   <= LAT;
                    r_state <= WAIT;
                end
                WAIT: if (w_fire) begin
                    r_state      <= RESP;
                    r_resp_valid <= 1'b1;
                    r_resp_err   <= r_err;
                    r_resp_rdata <= (r_err || r_write) ? '0 : w_ram_rdata;
                end else begin
                    r_cnt <= r_cnt - 4'd1;
                end
                default: r_state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_mem_responder.sv
// tb_mem_responder: directed table, reset corners and randomized traffic against a word-array model
module tb_mem_responder;
    logic cclk = 1'b0;
    logic rstb = 1'b0;
    int   checks = 0;
    int   errors = 0;
    logic [31:0] mem [256];

    always #5 cclk = ~cclk;

    mem_responder_if bus2 ();
    mem_responder_if bus0 ();

    mem_responder #(.LATENCY(2)) dut (.cclk(cclk), .rstb(rstb), .bus(bus2.slave));
    mem_responder #(.LATENCY(0)) dut0 (.cclk(cclk), .rstb(rstb), .bus(bus0.slave));

    typedef struct {
        bit          write;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [31:0] exp_rdata;
        bit          exp_err;
    } vec_t;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got=%h want=%h", name, act, exp);
        end
    endtask

    // spec rules: misaligned or index beyond DEPTH is an error; stores return zero data
    function automatic void model(input bit w, input logic [31:0] a, input logic [31:0] wd,
                                  output logic [31:0] rd, output bit e);
        e  = (a[1:0] != 2'b00) || (a[31:2] >= 30'd256);
        rd = (e || w) ? 32'h0 : mem[a[9:2]];
        if (w && !e) mem[a[9:2]] = wd;
    endfunction

    task automatic txn(virtual mem_responder_if vif, input int lat, input string name,
                       input bit w, input logic [31:0] a, input logic [31:0] wd,
                       input logic [31:0] exp_rd, input bit exp_err);
        int k = 0;
        int low = 0;
        @(negedge cclk);
        vif.req_valid = 1'b1;
        vif.req_write = w;
        vif.req_addr  = a;
        vif.req_wdata = wd;
        while (!vif.req_ready && k < 50) begin
            @(negedge cclk);
            k++;
        end
        chk({name, "_ready"}, 32'(vif.req_ready), 32'd1);
        @(negedge cclk);
        vif.req_write = 1'b1;
        vif.req_addr  = 32'h30;
        vif.req_wdata = $urandom;
        k = 1;
        while (!vif.resp_valid && k < 40) begin
            if (!vif.req_ready) low++;
            @(negedge cclk);
            k++;
        end
        if (!vif.req_ready) low++;
        vif.req_valid = 1'b0;
        chk({name, "_edges"}, 32'(k - 1), 32'(lat + 1));
        chk({name, "_rdata"}, vif.resp_rdata, exp_rd);
        chk({name, "_err"}, 32'(vif.resp_err), 32'(exp_err));
        @(negedge cclk);
        chk({name, "_resp_pulse"}, 32'(vif.resp_valid), 32'd0);
        chk({name, "_idle_again"}, 32'(vif.busy), 32'd0);
        chk({name, "_ready_low"}, 32'(low), 32'(lat + 2));
    endtask

    initial begin
        vec_t        vecs[$];
        logic [31:0] rd;
        bit          e;
        bus2.req_valid = 1'b1; bus2.req_write = 1'b1; bus2.req_addr = 32'h40; bus2.req_wdata = 32'h0;
        bus0.req_valid = 1'b1; bus0.req_write = 1'b1; bus0.req_addr = 32'h40; bus0.req_wdata = 32'h0;
        rstb = 1'b0;
        repeat (2) @(posedge cclk);
        @(negedge cclk);
        chk("rst_resp_valid", 32'(bus2.resp_valid), 32'd0);
        chk("rst_busy", 32'(bus2.busy), 32'd0);
        chk("rst_ready", 32'(bus2.req_ready), 32'd1);
        chk("rst_rdata", bus2.resp_rdata, 32'h0);
        chk("rst_err", 32'(bus2.resp_err), 32'd0);
        chk("rst_ready0", 32'(bus0.req_ready), 32'd1);
        rstb = 1'b1;
        bus2.req_valid = 1'b0;
        bus0.req_valid = 1'b0;
        @(negedge cclk);
        chk("post_rst_busy", 32'(bus2.busy), 32'd0);

        vecs.push_back('{1'b1, 32'h0000_0010, 32'hDEAD_BEEF, 32'h0,         1'b0});
        vecs.push_back('{1'b0, 32'h0000_0010, 32'h0,         32'hDEAD_BEEF, 1'b0});
        vecs.push_back('{1'b1, 32'h0000_0012, 32'h1234_5678, 32'h0,         1'b1});
        vecs.push_back('{1'b0, 32'h0000_0010, 32'h0,         32'hDEAD_BEEF, 1'b0});
        vecs.push_back('{1'b0, 32'h0000_0400, 32'h0,         32'h0,         1'b1});
        vecs.push_back('{1'b1, 32'h0000_0020, 32'h1111_2222, 32'h0,         1'b0});
        vecs.push_back('{1'b1, 32'h0000_03FC, 32'h5555_AAAA, 32'h0,         1'b0});
        vecs.push_back('{1'b0, 32'h0000_03FC, 32'h0,         32'h5555_AAAA, 1'b0});
        vecs.push_back('{1'b0, 32'h8000_0010, 32'h0,         32'h0,         1'b1});
        vecs.push_back('{1'b1, 32'h0000_0401, 32'h7777_7777, 32'h0,         1'b1});
        vecs.push_back('{1'b0, 32'h0000_0020, 32'h0,         32'h1111_2222, 1'b0});
        foreach (vecs[i]) begin
            model(vecs[i].write, vecs[i].addr, vecs[i].wdata, rd, e);
            txn(bus2, 2, $sformatf("vec%0d", i), vecs[i].write, vecs[i].addr, vecs[i].wdata,
                vecs[i].exp_rdata, vecs[i].exp_err);
        end

        // reset one edge after accepting a store: nothing commits, no response appears
        @(negedge cclk);
        bus2.req_valid = 1'b1; bus2.req_write = 1'b1; bus2.req_addr = 32'h20; bus2.req_wdata = 32'hA5A5_A5A5;
        @(posedge cclk);
        @(negedge cclk);
        chk("abort_accepted", 32'(bus2.busy), 32'd1);
        rstb = 1'b0;
        bus2.req_write = 1'b0; bus2.req_addr = 32'h30;
        @(negedge cclk);
        chk("abort_idle", 32'(bus2.busy), 32'd0);
        chk("abort_ready", 32'(bus2.req_ready), 32'd1);
        rstb = 1'b1;
        bus2.req_valid = 1'b0;
        begin
            int seen = 0;
            repeat (6) begin
                @(negedge cclk);
                if (bus2.resp_valid || bus2.busy) seen++;
            end
            chk("abort_no_resp", 32'(seen), 32'd0);
        end
        model(1'b0, 32'h20, 32'h0, rd, e);
        txn(bus2, 2, "abort_reload", 1'b0, 32'h20, 32'h0, rd, e);

        txn(bus0, 0, "l0_store", 1'b1, 32'h8, 32'hCAFE_F00D, 32'h0, 1'b0);
        txn(bus0, 0, "l0_load", 1'b0, 32'h8, 32'h0, 32'hCAFE_F00D, 1'b0);
        txn(bus0, 0, "l0_oor", 1'b0, 32'h0000_0404, 32'h0, 32'h0, 1'b1);

        for (int i = 0; i < 16; i++) begin
            logic [31:0] d = $urandom;
            model(1'b1, 32'(i * 4), d, rd, e);
            txn(bus2, 2, $sformatf("pre%0d", i), 1'b1, 32'(i * 4), d, rd, e);
        end
        for (int i = 0; i < 40; i++) begin
            int          sel = $urandom_range(0, 9);
            int          idx = $urandom_range(0, 15);
            bit          w   = 1'($urandom_range(0, 1));
            logic [31:0] d   = $urandom;
            logic [31:0] a;
            a = (sel == 0) ? 32'(idx * 4 + $urandom_range(1, 3)) :
                (sel == 1) ? 32'(32'h400 + idx * 4) : 32'(idx * 4);
            model(w, a, d, rd, e);
            txn(bus2, 2, $sformatf("rnd%0d", i), w, a, d, rd, e);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
